// File: rtl/sap_core.sv
// SAP-style accumulator processor: parametrised data/address width, program-load
// port, and a HALT/F0/F1/E0/E1 state machine that advances only on ce edges.
`timescale 1ns/1ps
module sap_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ce,
  input  logic              run,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] a_reg,
  output logic              cf,
  output logic              zf
);

  typedef enum logic [2:0] {S_HALT, S_F0, S_F1, S_E0, S_E1} state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_pc, r_mar;
  logic [DATA_W-1:0]   r_a, r_b, r_ir, r_out;
  logic                r_cf, r_zf, r_out_vld;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic [3:0]          w_op;
  logic [ADDR_W-1:0]   w_operand;
  logic [DATA_W-1:0]   w_mem_rd;
  logic [DATA_W:0]     w_sum;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_unused_ir_b;

  // Subtraction is two's-complement addition, so cf=1 means "no borrow".
  function automatic logic [DATA_W:0] alu(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] m,
                                          input logic sub);
    if (sub) alu = {1'b0, a} + {1'b0, ~m} + (DATA_W+1)'(1);
    else     alu = {1'b0, a} + {1'b0, m};
  endfunction

  assign w_op          = r_ir[DATA_W-1 -: 4];
  assign w_operand     = r_ir[ADDR_W-1:0];
  assign w_mem_rd      = r_mem[r_mar];
  assign w_sum         = alu(r_a, w_mem_rd, (w_op == OP_SUB));
  assign w_unused_ir_b = ^{r_ir, r_b};

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = ld_addr;
    w_mem_wdata = ld_data;
    if (r_state == S_HALT && ld_we) begin
      w_mem_we = 1'b1;
    end else if (ce && r_state == S_E1 && w_op == OP_STA) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_mar;
      w_mem_wdata = r_a;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_comb begin
    w_next = r_state;
    if (ce) begin
      case (r_state)
        S_HALT: if (run) w_next = S_F0;
        S_F0:   w_next = S_F1;
        S_F1:   w_next = S_E0;
        S_E0: begin
          case (w_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: w_next = S_E1;
            OP_HLT:                         w_next = S_HALT;
            default:                        w_next = S_F0;
          endcase
        end
        S_E1:    w_next = S_F0;
        default: w_next = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_HALT;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pc      <= '0;
      r_mar     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_ir      <= '0;
      r_out     <= '0;
      r_cf      <= 1'b0;
      r_zf      <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      // Evaluated every clk so the pulse stays one clk wide even with ce low.
      r_out_vld <= ce && (r_state == S_E0) && (w_op == OP_OUT);
      if (ce) begin
        case (r_state)
          S_F0: r_mar <= r_pc;
          S_F1: begin
            r_ir <= w_mem_rd;
            r_pc <= r_pc + ADDR_W'(1);
          end
          S_E0: begin
            case (w_op)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_operand;
              OP_LDI: r_a   <= DATA_W'(w_operand);
              OP_JMP: r_pc  <= w_operand;
              OP_JC:  if (r_cf) r_pc <= w_operand;
              OP_JZ:  if (r_zf) r_pc <= w_operand;
              OP_OUT: r_out <= r_a;
              default: ;
            endcase
          end
          S_E1: begin
            case (w_op)
              OP_LDA: r_a <= w_mem_rd;
              OP_ADD, OP_SUB: begin
                r_a  <= w_sum[DATA_W-1:0];
                r_cf <= w_sum[DATA_W];
                r_zf <= (w_sum[DATA_W-1:0] == '0);
                r_b  <= w_mem_rd;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_out_vld;
  assign halted    = (r_state == S_HALT);
  assign pc        = r_pc;
  assign a_reg     = r_a;
  assign cf        = r_cf;
  assign zf        = r_zf;

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core: table of arithmetic vectors plus hand-built
// programs for fetch/execute timing, stalls, reset, load gating and wrap.
`timescale 1ns/1ps
module tb_sap_core;

  logic        clk = 1'b0;
  logic        clr_n, ce, run, ld_we;
  logic [7:0]  ld_addr;
  logic [11:0] ld_data;

  logic [7:0]  out_data, a_reg;
  logic [3:0]  pc;
  logic        out_valid, halted, cf, zf;

  logic [11:0] g_out_data, g_a_reg;
  logic [7:0]  g_pc;
  logic        g_out_valid, g_halted, g_cf, g_zf;

  int tests = 0;
  int fails = 0;
  logic [7:0]  oq[$];
  logic [11:0] g_oq[$];

  sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .run(run), .ld_we(ld_we),
    .ld_addr(ld_addr[3:0]), .ld_data(ld_data[7:0]),
    .out_data(out_data), .out_valid(out_valid), .halted(halted),
    .pc(pc), .a_reg(a_reg), .cf(cf), .zf(zf)
  );

  sap_core #(.DATA_W(12), .ADDR_W(8)) g_dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .run(run), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .out_data(g_out_data), .out_valid(g_out_valid), .halted(g_halted),
    .pc(g_pc), .a_reg(g_a_reg), .cf(g_cf), .zf(g_zf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1)   oq.push_back(out_data);
    if (g_out_valid === 1'b1) g_oq.push_back(g_out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    tick();
    oq.delete();
    g_oq.delete();
  endtask

  task automatic load(input int addr, input int data);
    ld_addr = addr[7:0];
    ld_data = data[11:0];
    ld_we   = 1'b1;
    ce      = 1'b0;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1;
    ce  = 1'b1;
    tick();
    run = 1'b0;
    ce  = 1'b0;
  endtask

  task automatic step(input int n);
    ce = 1'b1;
    repeat (n) tick();
    ce = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    ce = 1'b1;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ce = 1'b0;
    chk("halt_within_budget", halted, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp_a;
    logic       exp_cf;
    logic       exp_zf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] ma;
    logic [8:0] s;
    logic [7:0] expq[$];

    tbl[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
    tbl[1] = '{8'd3,   8'd5,   1'b1, 8'd254, 1'b0, 1'b0};
    tbl[2] = '{8'd7,   8'd7,   1'b1, 8'd0,   1'b1, 1'b1};
    tbl[3] = '{8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 1'b0};
    tbl[4] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b1};
    tbl[5] = '{8'd9,   8'd4,   1'b1, 8'd5,   1'b1, 1'b0};

    clr_n = 1'b0; ce = 1'b0; run = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_data = '0;
    #2;
    chk("rst_halted", halted, 1);
    chk("rst_pc", pc, 0);
    chk("rst_a", a_reg, 0);
    chk("rst_cf", cf, 0);
    chk("rst_zf", zf, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    #10;
    clr_n = 1'b1;
    tick();

    // Sum-and-output with exact cycle count
    load(0, 8'h1E); load(1, 8'h2F); load(2, 8'hE0); load(3, 8'hF0);
    load(14, 5); load(15, 3);
    oq.delete();
    run_pulse();
    chk("sum_running", halted, 0);
    step(13);
    chk("sum_not_halted_13", halted, 0);
    step(1);
    chk("sum_halted_14", halted, 1);
    chk("sum_out_count", oq.size(), 1);
    if (oq.size() > 0) chk("sum_out_val", oq[0], 8);
    chk("sum_cf", cf, 0);
    chk("sum_zf", zf, 0);
    chk("sum_pc", pc, 4);

    // Arithmetic vector table: LDA 14; ADD/SUB 15; HLT
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load(0, 8'h1E); load(1, tbl[i].sub ? 8'h3F : 8'h2F); load(2, 8'hF0);
      load(14, tbl[i].a); load(15, tbl[i].b);
      run_pulse();
      wait_halt(40);
      chk($sformatf("vec%0d_a", i), a_reg, tbl[i].exp_a);
      chk($sformatf("vec%0d_cf", i), cf, tbl[i].exp_cf);
      chk($sformatf("vec%0d_zf", i), zf, tbl[i].exp_zf);
      chk($sformatf("vec%0d_pc", i), pc, 3);
    end

    // LDI 7; SUB 15 (=7); JZ 0 taken
    do_reset();
    load(0, 8'h57); load(1, 8'h3F); load(2, 8'h80); load(3, 8'hF0); load(15, 7);
    run_pulse();
    step(10);
    chk("jz_pc", pc, 0);
    chk("jz_a", a_reg, 0);
    chk("jz_cf", cf, 1);
    chk("jz_zf", zf, 1);
    chk("jz_running", halted, 0);

    // Counting loop: LDI 0; OUT; ADD 15(=64); JC 5; JMP 1; HLT
    do_reset();
    load(0, 8'h50); load(1, 8'hE0); load(2, 8'h2F); load(3, 8'h75);
    load(4, 8'h61); load(5, 8'hF0); load(15, 64);
    ma = 8'd0;
    do begin
      expq.push_back(ma);
      s  = {1'b0, ma} + 9'd64;
      ma = s[7:0];
    end while (!s[8]);
    run_pulse();
    wait_halt(300);
    chk("loop_out_count", oq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < oq.size(); i++)
      chk($sformatf("loop_out%0d", i), oq[i], expq[i]);
    chk("loop_cf", cf, 1);
    chk("loop_pc", pc, 6);

    // NOP-filled RAM with HLT at 0: PC wraps
    do_reset();
    for (int i = 0; i < 16; i++) load(i, 8'h00);
    load(0, 8'hF0);
    run_pulse();
    wait_halt(10);
    chk("wrap_first_pc", pc, 1);
    run_pulse();
    step(45);
    chk("wrap_pc0", pc, 0);
    chk("wrap_running", halted, 0);
    step(3);
    chk("wrap_halted", halted, 1);
    chk("wrap_final_pc", pc, 1);

    // Load gating: write during F1 ignored, write in HALT (with run) honoured
    do_reset();
    load(0, 8'h1E); load(1, 8'hF0); load(2, 8'h1E); load(3, 8'hF0); load(14, 8'h11);
    run_pulse();
    step(1);
    ld_addr = 8'd14; ld_data = 12'h099; ld_we = 1'b1; ce = 1'b1;
    tick();
    ld_we = 1'b0; ce = 1'b0;
    wait_halt(20);
    chk("ldgate_ignored", a_reg, 8'h11);
    ld_addr = 8'd14; ld_data = 12'h099; ld_we = 1'b1; run = 1'b1; ce = 1'b1;
    tick();
    ld_we = 1'b0; run = 1'b0; ce = 1'b0;
    chk("ldrun_left_halt", halted, 0);
    wait_halt(20);
    chk("ldgate_honoured", a_reg, 8'h99);

    // ce stall mid-ADD: LDI 5; ADD 15(=3); HLT
    do_reset();
    load(0, 8'h55); load(1, 8'h2F); load(2, 8'hF0); load(15, 3);
    run_pulse();
    step(5);
    repeat (10) tick();
    chk("stall_pc", pc, 2);
    chk("stall_a", a_reg, 5);
    chk("stall_running", halted, 0);
    chk("stall_cf", cf, 0);
    step(2);
    chk("stall_sum", a_reg, 8);

    // out_valid width with ce dropping after the OUT E0 edge
    do_reset();
    load(0, 8'h59); load(1, 8'hE0); load(2, 8'hF0);
    run_pulse();
    step(5);
    chk("ov_before", out_valid, 0);
    step(1);
    chk("ov_pulse", out_valid, 1);
    chk("ov_data", out_data, 9);
    tick();
    chk("ov_cleared", out_valid, 0);
    tick();
    chk("ov_count", oq.size(), 1);

    // STA then reload: write visible to later LDA
    do_reset();
    load(0, 8'h59); load(1, 8'h4E); load(2, 8'h50); load(3, 8'h1E); load(4, 8'hF0);
    load(14, 8'h00);
    run_pulse();
    wait_halt(40);
    chk("sta_visible", a_reg, 9);

    // clr_n asserted during STA E1
    do_reset();
    load(0, 8'h59); load(1, 8'h4E); load(2, 8'hF0); load(14, 8'h33);
    run_pulse();
    step(6);
    #2;
    clr_n = 1'b0;
    #1;
    chk("clr_halted", halted, 1);
    chk("clr_pc", pc, 0);
    chk("clr_a", a_reg, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_data", out_data, 0);
    tick();
    clr_n = 1'b1;
    load(0, 8'h1E); load(1, 8'hF0);
    run_pulse();
    wait_halt(20);
    chk("clr_ram_kept", a_reg, 8'h33);

    // Generic 12/8 core: HLT@0, JMP 200 @1, LDA 199; JMP 255; OUT at 255; wrap to HLT@0
    do_reset();
    load(0, 12'hF00); load(1, 12'h6C8); load(199, 12'hFFF);
    load(200, 12'h1C7); load(201, 12'h6FF); load(255, 12'hE00);
    run_pulse();
    step(3);
    chk("gen_first_halt", g_halted, 1);
    chk("gen_first_pc", g_pc, 1);
    g_oq.delete();
    run_pulse();
    step(13);
    chk("gen_wrap_pc", g_pc, 0);
    chk("gen_running", g_halted, 0);
    chk("gen_a", g_a_reg, 12'hFFF);
    step(3);
    chk("gen_halted", g_halted, 1);
    chk("gen_final_pc", g_pc, 1);
    chk("gen_out_count", g_oq.size(), 1);
    if (g_oq.size() > 0) chk("gen_out_val", g_oq[0], 12'hFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
